// File: rtl/updown_counter_gen2.sv
// Parametrised loadable up/down counter with step, enable and
// wrap / saturate / one-shot terminal behaviour plus sticky flags.
module updown_counter_gen2 #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 11,
    parameter int STEP_W  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [WIDTH-1:0]  din,
    input  logic              load,
    input  logic              en,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              done,
    output logic              ovf,
    output logic              udf,
    output logic              load_err
);

    localparam int XW = WIDTH + 2;
    localparam logic [XW-1:0] XMIN = XW'(MIN_VAL);
    localparam logic [XW-1:0] XMAX = XW'(MAX_VAL);
    localparam logic [XW-1:0] XR   = XW'(MAX_VAL - MIN_VAL + 1);
    localparam logic [WIDTH-1:0] CMIN = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] CMAX = WIDTH'(MAX_VAL);

    typedef enum logic {RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_d;
    logic              tc_d;
    logic              ovf_set, udf_set, lerr_set;
    logic [XW-1:0]     cnt_x, stp_x, din_x;
    logic [XW-1:0]     up_x, dn_x, upw_x, dnw_x;
    logic              up_cross, dn_cross;
    logic              is_sat, is_one, din_lo, din_hi;

    // Extra headroom bits keep sums and differences from folding at 2**WIDTH
    assign cnt_x    = XW'(count);
    assign stp_x    = XW'(step);
    assign din_x    = XW'(din);
    assign up_x     = cnt_x + stp_x;
    assign dn_x     = cnt_x - stp_x;
    assign upw_x    = up_x - XR;
    assign dnw_x    = cnt_x + XR - stp_x;
    assign up_cross = up_x > XMAX;
    assign dn_cross = cnt_x < (XMIN + stp_x);
    assign is_sat   = (mode == 2'b01);
    assign is_one   = (mode == 2'b10);
    assign din_lo   = din_x < XMIN;
    assign din_hi   = din_x > XMAX;

    always_comb begin
        state_d  = state_q;
        count_d  = count;
        tc_d     = 1'b0;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        lerr_set = 1'b0;
        if (load) begin
            state_d  = RUN;
            lerr_set = din_lo | din_hi;
            unique case (1'b1)
                din_lo:  count_d = CMIN;
                din_hi:  count_d = CMAX;
                default: count_d = din;
            endcase
        end else if (en && state_q == RUN) begin
            if (up_down) begin
                if (up_cross) begin
                    tc_d    = 1'b1;
                    ovf_set = 1'b1;
                    unique case (1'b1)
                        is_sat:  count_d = CMAX;
                        is_one: begin
                            count_d = CMAX;
                            state_d = DONE;
                        end
                        default: count_d = upw_x[WIDTH-1:0];
                    endcase
                end else begin
                    count_d = up_x[WIDTH-1:0];
                end
            end else begin
                if (dn_cross) begin
                    tc_d    = 1'b1;
                    udf_set = 1'b1;
                    unique case (1'b1)
                        is_sat:  count_d = CMIN;
                        is_one: begin
                            count_d = CMIN;
                            state_d = DONE;
                        end
                        default: count_d = dnw_x[WIDTH-1:0];
                    endcase
                end else begin
                    count_d = dn_x[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= RUN;
            count    <= CMIN;
            tc       <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            tc       <= tc_d;
            done     <= (state_d == DONE);
            // A set event in the same cycle as a clear keeps the flag
            ovf      <= ovf_set  | (ovf      & ~clr_flags);
            udf      <= udf_set  | (udf      & ~clr_flags);
            load_err <= lerr_set | (load_err & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_updown_counter_gen2.sv
// Directed bench for updown_counter_gen2: wrap, saturate, one-shot,
// load clamping, flag clearing and asynchronous reset.
module tb_updown_counter_gen2;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [3:0] din = '0;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b1;
    logic [1:0] step = '0;
    logic [1:0] mode = '0;
    logic       clr_flags = 1'b0;
    logic [3:0] count;
    logic       tc, done, ovf, udf, load_err;

    int n_chk = 0;
    int n_err = 0;
    int tc_seen;

    updown_counter_gen2 #(
        .WIDTH(4), .MIN_VAL(0), .MAX_VAL(11), .STEP_W(2)
    ) dut (
        .clk(clk), .resetn(resetn), .din(din), .load(load), .en(en),
        .up_down(up_down), .step(step), .mode(mode),
        .clr_flags(clr_flags), .count(count), .tc(tc), .done(done),
        .ovf(ovf), .udf(udf), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset then wrap up
        #2 resetn = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_tc", tc, 0);
        check("rst_done", done, 0);
        check("rst_flags", {ovf, udf, load_err}, 0);
        tick();
        #2 resetn = 1'b1;
        tick();
        mode = 2'b00; up_down = 1'b1; step = 2'd1; en = 1'b1;
        tc_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("wrap_up_count", count, k % 12);
            if (tc) tc_seen++;
            if (k == 12) check("wrap_up_tc_at0", tc, 1);
        end
        check("wrap_up_tc_once", tc_seen, 1);
        check("wrap_up_ovf", ovf, 1);
        en = 1'b0;

        // 2: wrap down with step 3
        din = 4'd1; load = 1'b1;
        tick();
        load = 1'b0;
        check("ld1_count", count, 1);
        up_down = 1'b0; step = 2'd3; en = 1'b1;
        tick();
        check("wrap_dn_count", count, 10);
        check("wrap_dn_tc", tc, 1);
        check("wrap_dn_udf", udf, 1);
        tick();
        check("wrap_dn_count2", count, 7);
        check("wrap_dn_tc2", tc, 0);
        en = 1'b0;

        // 3: saturate
        din = 4'd10; load = 1'b1; clr_flags = 1'b1;
        tick();
        load = 1'b0; clr_flags = 1'b0;
        check("sat_ld_count", count, 10);
        check("sat_ld_ovf", ovf, 0);
        mode = 2'b01; up_down = 1'b1; step = 2'd3; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sat_count", count, 11);
            check("sat_tc", tc, 1);
        end
        check("sat_ovf", ovf, 1);
        en = 1'b0; clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("sat_clr_ovf", ovf, 0);
        check("sat_hold_tc", tc, 0);

        // 4: one-shot; 9+2 lands on 11 without crossing
        din = 4'd9; load = 1'b1;
        tick();
        load = 1'b0;
        mode = 2'b10; up_down = 1'b1; step = 2'd2; en = 1'b1;
        tick();
        check("os_count1", count, 11);
        check("os_done1", done, 0);
        tick();
        check("os_count2", count, 11);
        check("os_done2", done, 1);
        check("os_tc2", tc, 1);
        tick();
        check("os_hold_count", count, 11);
        check("os_hold_tc", tc, 0);
        mode = 2'b00;
        tick();
        check("os_mode_done", done, 1);
        check("os_mode_count", count, 11);
        en = 1'b0; din = 4'd4; load = 1'b1;
        tick();
        load = 1'b0;
        check("os_ld_done", done, 0);
        check("os_ld_count", count, 4);

        // 5: load clamp beats enable; set beats clear
        din = 4'd14; load = 1'b1; en = 1'b1; clr_flags = 1'b1;
        mode = 2'b00; up_down = 1'b1; step = 2'd1;
        tick();
        load = 1'b0;
        check("clamp_count", count, 11);
        check("clamp_lerr", load_err, 1);
        check("clamp_ovf_clr", ovf, 0);
        check("clamp_tc", tc, 0);
        tick();
        clr_flags = 1'b0; en = 1'b0;
        check("setwin_count", count, 0);
        check("setwin_ovf", ovf, 1);
        check("setwin_lerr", load_err, 0);
        check("setwin_tc", tc, 1);

        // 6: async reset while in DONE
        din = 4'd9; load = 1'b1;
        tick();
        load = 1'b0;
        mode = 2'b10; step = 2'd2; en = 1'b1;
        tick();
        tick();
        check("ar_pre_done", done, 1);
        check("ar_pre_count", count, 11);
        #2 resetn = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_done", done, 0);
        check("ar_flags", {ovf, udf, load_err}, 0);
        tick();
        check("ar_hold_count", count, 0);
        #2 resetn = 1'b1;
        mode = 2'b00; step = 2'd1;
        tick();
        check("ar_resume1", count, 1);
        tick();
        check("ar_resume2", count, 2);
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
